trigger_tcm_tx: RTL and testbench

TRIGGER_TCM_TX -- requirements
Module: trigger_tcm_tx

---
 rtl/trigger_tcm_tx.sv | 159 +++++++++++++++
 tb/tb_trigger_tcm_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_tcm_tx.sv
// trigger_tcm_tx: captures trigger results into a small FIFO and streams each
// record to the TCM link as a 7-byte frame (header, 5 record bytes, XOR checksum).
`default_nettype none

module trigger_tcm_tx #(
    parameter logic [2:0] CAPTURE_PHASE = 3'd0,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic        clk320,
    input  logic        rst,
    input  logic [2:0]  mt_cou,
    input  logic        orbit_sync,
    input  logic        tcm_req,
    input  logic [9:0]  tt,
    input  logic [12:0] ta,
    input  logic [4:0]  trig,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        fifo_full,
    output logic [7:0]  ovf_cnt
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [11:0] BC_MAX = 12'd3563;
    localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;

    state_t        state, state_nxt;
    logic [11:0]   bc;
    logic [39:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic [39:0]   rec;
    logic [2:0]    idx;
    logic          capture, push, pop, drop, empty;

    assign empty   = (count == '0);
    assign capture = (mt_cou == CAPTURE_PHASE) && tcm_req;
    // A full FIFO still accepts a capture when a record leaves on the same edge.
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk320) begin
        if (rst) begin
            bc <= '0;
        end else if (mt_cou == 3'd7) begin
            if (orbit_sync || bc == BC_MAX)
                bc <= '0;
            else
                bc <= bc + 12'd1;
        end
    end

    always_ff @(posedge clk320) begin
        if (push)
            mem[wr_ptr] <= {bc, trig, tt, ta};
    end

    always_ff @(posedge clk320) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            fifo_full <= (count_nxt == DEPTH);
            if (drop && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk320) begin
        if (rst) begin
            state <= IDLE;
            rec   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                rec <= mem[rd_ptr];
                idx <= '0;
            end else if (state == PAY && tx_ready) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready)
                    state_nxt = PAY;
            end
            PAY: begin
                tx_valid = 1'b1;
                case (idx)
                    3'd0:    tx_data = rec[39:32];
                    3'd1:    tx_data = rec[31:24];
                    3'd2:    tx_data = rec[23:16];
                    3'd3:    tx_data = rec[15:8];
                    3'd4:    tx_data = rec[7:0];
                    default: tx_data = 8'h00;
                endcase
                if (tx_ready && idx == 3'd4)
                    state_nxt = CSUM;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = HEADER ^ rec[39:32] ^ rec[31:24] ^ rec[23:16]
                         ^ rec[15:8] ^ rec[7:0];
                if (tx_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = HDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trigger_tcm_tx.sv
// tb_trigger_tcm_tx: random and directed stimulus against a frame-level
// reference model (record queue plus one frame in flight).
`default_nettype none

module tb_trigger_tcm_tx;

    localparam logic [2:0] CP    = 3'd0;
    localparam int         DEPTH = 4;
    localparam logic [7:0] HB    = 8'hA5;

    logic        clk320 = 1'b0;
    logic        rst;
    logic [2:0]  mt_cou;
    logic        orbit_sync;
    logic        tcm_req;
    logic [9:0]  tt;
    logic [12:0] ta;
    logic [4:0]  trig;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        fifo_full;
    logic [7:0]  ovf_cnt;

    trigger_tcm_tx #(
        .CAPTURE_PHASE(CP),
        .FIFO_DEPTH   (DEPTH),
        .HEADER       (HB)
    ) dut (
        .clk320    (clk320),
        .rst       (rst),
        .mt_cou    (mt_cou),
        .orbit_sync(orbit_sync),
        .tcm_req   (tcm_req),
        .tt        (tt),
        .ta        (ta),
        .trig      (trig),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .fifo_full (fifo_full),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk320 = ~clk320;

    logic [39:0] mq [$];
    logic [7:0]  m_frame [7];
    bit          m_busy;
    int          m_sent;
    int          m_ovf;
    int          m_bc;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [39:0] r);
        logic [7:0] x;
        m_frame[0] = HB;
        x = HB;
        for (int k = 0; k < 5; k++) begin
            m_frame[k+1] = 8'(r >> (8 * (4 - k)));
            x = x ^ m_frame[k+1];
        end
        m_frame[6] = x;
    endfunction

    // One clock: update the model with the inputs seen at the edge, then check.
    task automatic tick();
        bit hs, done, pop, cap, push;
        logic [39:0] r;
        @(posedge clk320);
        if (rst) begin
            mq.delete();
            m_busy = 0;
            m_sent = 0;
            m_ovf  = 0;
            m_bc   = 0;
        end else begin
            hs   = m_busy && tx_ready;
            done = hs && (m_sent == 6);
            pop  = (mq.size() > 0) && (!m_busy || done);
            cap  = (mt_cou == CP) && tcm_req;
            push = cap && ((mq.size() < DEPTH) || pop);
            r    = {12'(m_bc), trig, tt, ta};
            if (cap && !push && m_ovf < 255)
                m_ovf++;
            if (hs)
                m_sent++;
            if (done) begin
                m_busy = 0;
                m_sent = 0;
            end
            if (pop) begin
                build_frame(mq.pop_front());
                m_busy = 1;
                m_sent = 0;
            end
            if (push)
                mq.push_back(r);
            if (mt_cou == 3'd7)
                m_bc = orbit_sync ? 0 : ((m_bc == 3563) ? 0 : m_bc + 1);
        end
        #1;
        check_val("tx_valid", tx_valid, m_busy);
        check_val("tx_data", tx_data, m_busy ? m_frame[m_sent] : 8'h00);
        check_val("tx_last", tx_last, m_busy && (m_sent == 6));
        check_val("fifo_full", fifo_full, mq.size() == DEPTH);
        check_val("ovf_cnt", ovf_cnt, 8'(m_ovf));
        mt_cou = mt_cou + 3'd1;
    endtask

    task automatic rand_words();
        trig = 5'($urandom);
        tt   = 10'($urandom);
        ta   = 13'($urandom);
    endtask

    task automatic drain();
        int i;
        tcm_req  = 1'b0;
        tx_ready = 1'b1;
        i = 0;
        while ((m_busy || mq.size() > 0) && i < 2000) begin
            tick();
            i++;
        end
        check_val("drain_timeout", (m_busy || mq.size() > 0), 1'b0);
        repeat (3) tick();
    endtask

    task automatic orbit();
        while (mt_cou != 3'd7)
            tick();
        orbit_sync = 1'b1;
        tick();
        orbit_sync = 1'b0;
    endtask

    initial begin
        int n_rec;
        int guard;
        rst        = 1'b1;
        mt_cou     = 3'd0;
        orbit_sync = 1'b0;
        tcm_req    = 1'b0;
        tt         = '0;
        ta         = '0;
        trig       = '0;
        tx_ready   = 1'b1;
        m_busy     = 0;
        m_sent     = 0;
        m_ovf      = 0;
        m_bc       = 0;

        // Reset, including a capture request that must be ignored
        tcm_req = 1'b1;
        repeat (10) tick();
        tcm_req = 1'b0;
        rst     = 1'b0;

        // Directed frame captured in BC 5
        orbit();
        while (!(m_bc == 5 && mt_cou == CP))
            tick();
        tcm_req = 1'b1;
        trig    = 5'h11;
        tt      = 10'h155;
        ta      = 13'h0AAA;
        tick();
        tcm_req = 1'b0;
        drain();

        // BC wrap after a full orbit without orbit_sync
        orbit();
        repeat (3564 * 8) tick();
        tcm_req = 1'b1;
        rand_words();
        tick();
        tcm_req = 1'b0;
        drain();

        // Stalled link with a capture every BC: fills the FIFO and overflows
        tx_ready = 1'b0;
        tcm_req  = 1'b1;
        repeat (60) begin
            rand_words();
            tick();
        end
        drain();

        // Random stalls, sparse captures
        n_rec = 0;
        guard = 0;
        while (n_rec < 1000 && guard < 40000) begin
            rand_words();
            tx_ready = 1'($urandom);
            tcm_req  = ($urandom_range(2) == 0);
            if (mt_cou == CP && tcm_req)
                n_rec++;
            tick();
            guard++;
        end
        drain();

        // Reset during the third payload byte with two records queued
        tx_ready = 1'b0;
        tcm_req  = 1'b1;
        while (mq.size() < 2 || !m_busy) begin
            rand_words();
            tick();
        end
        tcm_req  = 1'b0;
        tx_ready = 1'b1;
        guard = 0;
        while (!(m_busy && m_sent == 3) && guard < 50) begin
            tick();
            guard++;
        end
        check_val("reach_pay3", (m_busy && m_sent == 3), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
